cla_adder_pipe: RTL
===================

// Module: cla_adder_pipe
// PURPOSE
//  Parametrised two-stage pipelined carry-lookahead adder/subtractor. Splits a
//  WIDTH-bit operand pair into BLOCK-bit groups. Stage 1 registers per-group
//  generate/propagate. Stage 2 resolves group carries by lookahead and
//  registers sum, carry-out and signed overflow. Valid/ready handshake on both
//  sides with backpressure. Replaces the fixed 8-bit combinational CLA in the
//  ALU datapath.
// PARAMETERS
//  WIDTH  16  operand/sum width; must be a multiple of BLOCK (elab error otherwise)
//  BLOCK  4   bits per lookahead group; legal 1..5 (lookahead fan-in <= 6)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      operands/mode valid this cycle
//  in_ready   out  1      block can accept operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  carry_in   in   1      carry into bit 0 (ignored when sub=1)
//  sub        in   1      0: a+b+carry_in; 1: a-b = a+~b+1
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  carry_out  out  1      carry out of MSB (sub=1: 1 means no borrow)
//  overflow   out  1      signed overflow = carry into MSB XOR carry_out
// BEHAVIOUR
//  - Reset (async assert, sync release): v1, out_valid = 0; sum, carry_out,
//    overflow = 0; all stage-1 registers = 0.
//  - Stage 1 transfer: in_valid && in_ready. Registers a, b_eff = sub ? ~b : b,
//    c0 = sub ? 1 : carry_in. Also registers per group k: Pk = &(a^b_eff)[k],
//    Gk = group generate. Sets v1=1.
//  - Stage 2 transfer: v1 && s2_ready, where s2_ready = !out_valid || out_ready.
//    Computes Ck+1 = Gk | Pk&Gk-1 | ... | Pk..P0&c0. Forms in-group carries and
//    sum bits. Registers sum, carry_out, overflow. Sets out_valid=1.
//  - in_ready = !v1 || s2_ready. This is a combinational path from out_ready.
//  - Latency: operands accepted on edge N give out_valid=1 after edge N+1
//    (2 cycles). Throughput: 1 result/cycle when out_ready held high.
//  - v1 clears when stage 2 takes its data and no new input arrives that cycle.
//    out_valid clears on out_valid && out_ready with v1=0.
//  - Backpressure: while out_valid && !out_ready, sum/carry_out/overflow hold
//    stable and stage 1 holds. in_ready=0 once v1=1. No result is dropped or
//    duplicated.
//  - Simultaneous events: a result leaves, stage 1 advances and a new input
//    enters on the same edge. All three happen.
//  - Arithmetic: modulo 2^WIDTH, no saturation. Results are exact for all
//    operand values, including all-ones + 1 (full propagate chain).
//  - Reset mid-operation: in-flight results are discarded. Nothing is emitted
//    after reset release until new input.
//  - in_valid with X operands while in_ready=0 must not affect state.
// TESTING
//  1 WIDTH=16, out_ready=1: a=16'hFFFF, b=0, carry_in=1, sub=0 -> 2 cycles later
//    sum=0, carry_out=1, overflow=0.
//  2 sub=1, a=16'h8000, b=1 -> sum=16'h7FFF, carry_out=1, overflow=1.
//    Then a=3, b=5, sub=1 -> sum=16'hFFFE, carry_out=0, overflow=0.
//  3 Stream 8 back-to-back ops, out_ready=1 -> 8 results on consecutive cycles
//    in order, in_ready stays 1.
//  4 out_ready=0 for 5 cycles with in_valid=1 -> in_ready falls after 2
//    accepts, sum held stable. On release, results drain in order, none lost.
//  5 Assert rst with 2 ops in flight -> out_valid=0, sum=0 immediately
//    (async). No output after release until new input.
//  6 Random 10k ops, sub/carry_in random, WIDTH in {8,16,32}, BLOCK in {1,4,5},
//    random out_ready -> scoreboard matches a+b+cin / a-b and the overflow rule.

Source files
------------

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage 1 registers operands plus group generate/propagate; stage 2 resolves carries and registers the result.
module cla_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NG = WIDTH / BLOCK;

  generate
    if ((BLOCK < 1) || (BLOCK > 5) || ((WIDTH % BLOCK) != 0)) begin : g_param_check
      $error("cla_adder_pipe: WIDTH must be a multiple of BLOCK and BLOCK must be 1..5");
    end
  endgenerate

  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH-1:0] p_in_s;
  logic [WIDTH-1:0] g_in_s;
  logic [NG-1:0]    grp_p_s;
  logic [NG-1:0]    grp_g_s;
  logic             s1_fire_s;
  logic             s2_fire_s;
  logic             s2_ready_s;

  logic             v1_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             c0_r;
  logic [NG-1:0]    grp_p_r;
  logic [NG-1:0]    grp_g_r;

  logic [WIDTH-1:0] p2_s;
  logic [WIDTH-1:0] g2_s;
  logic [NG:0]      grp_c_s;
  logic [WIDTH-1:0] sum_s;
  logic             cout_s;
  logic             ovf_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  assign s2_ready_s = !out_valid_r || out_ready;
  assign in_ready   = !v1_r || s2_ready_s;
  assign s1_fire_s  = in_valid && in_ready;
  assign s2_fire_s  = v1_r && s2_ready_s;

  // Stage 1 operand conditioning and per-group generate/propagate
  always_comb begin
    logic g_acc;
    g_acc   = 1'b0;
    b_eff_s = sub ? ~b : b;
    p_in_s  = a ^ b_eff_s;
    g_in_s  = a & b_eff_s;
    grp_p_s = '0;
    grp_g_s = '0;
    for (int k = 0; k < NG; k++) begin
      grp_p_s[k] = &p_in_s[k*BLOCK +: BLOCK];
      g_acc = 1'b0;
      for (int i = 0; i < BLOCK; i++) begin
        g_acc = g_in_s[k*BLOCK+i] | (p_in_s[k*BLOCK+i] & g_acc);
      end
      grp_g_s[k] = g_acc;
    end
  end

  // Stage 2 group-carry lookahead, then in-group ripple to form sum bits
  always_comb begin
    logic term;
    logic c;
    logic c_msb;
    term    = 1'b0;
    c       = 1'b0;
    c_msb   = 1'b0;
    p2_s    = a_r ^ b_r;
    g2_s    = a_r & b_r;
    grp_c_s = '0;
    sum_s   = '0;
    grp_c_s[0] = c0_r;
    for (int k = 0; k < NG; k++) begin
      grp_c_s[k+1] = grp_g_r[k];
      term = grp_p_r[k];
      for (int j = k - 1; j >= 0; j--) begin
        grp_c_s[k+1] = grp_c_s[k+1] | (term & grp_g_r[j]);
        term = term & grp_p_r[j];
      end
      grp_c_s[k+1] = grp_c_s[k+1] | (term & c0_r);
    end
    for (int k = 0; k < NG; k++) begin
      c = grp_c_s[k];
      for (int i = 0; i < BLOCK; i++) begin
        sum_s[k*BLOCK+i] = p2_s[k*BLOCK+i] ^ c;
        c = g2_s[k*BLOCK+i] | (p2_s[k*BLOCK+i] & c);
      end
    end
    c_msb  = p2_s[WIDTH-1] ^ sum_s[WIDTH-1];
    cout_s = grp_c_s[NG];
    ovf_s  = c_msb ^ grp_c_s[NG];
  end

  // Stage 1 registers: load on accept, drain when stage 2 takes the data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r    <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      c0_r    <= 1'b0;
      grp_p_r <= '0;
      grp_g_r <= '0;
    end else if (s1_fire_s) begin
      v1_r    <= 1'b1;
      a_r     <= a;
      b_r     <= b_eff_s;
      c0_r    <= sub ? 1'b1 : carry_in;
      grp_p_r <= grp_p_s;
      grp_g_r <= grp_g_s;
    end else if (s2_ready_s) begin
      v1_r    <= 1'b0;
    end else begin
      v1_r    <= v1_r;
    end
  end

  // Stage 2 result registers: held stable while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (s2_fire_s) begin
      out_valid_r <= 1'b1;
      sum_r       <= sum_s;
      cout_r      <= cout_s;
      ovf_r       <= ovf_s;
    end else if (s2_ready_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign carry_out = cout_r;
  assign overflow  = ovf_r;

endmodule
